// File: rtl/bot_if_pkg.sv
// Shared definitions for the Rojobot snapshot/interrupt block: state encodings,
// status bit layout and the PicoBlaze port map for the snapshot registers.
package bot_if_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } intc_state_t;

    localparam int STS_TMO_BIT   = 7;
    localparam int STS_DEF_BIT   = 6;
    localparam int STS_STATE_HI  = 1;
    localparam int STS_STATE_LO  = 0;

    localparam int SNAP_N = 6;

    // Snapshot read ports; the 0x1x block mirrors the 0x0x block.
    localparam logic [7:0] PA_LOC_X       = 8'h0A;
    localparam logic [7:0] PA_LOC_Y       = 8'h0B;
    localparam logic [7:0] PA_BOTINFO     = 8'h0C;
    localparam logic [7:0] PA_SENSORS     = 8'h0D;
    localparam logic [7:0] PA_LMDIST      = 8'h0E;
    localparam logic [7:0] PA_RMDIST      = 8'h0F;
    localparam logic [7:0] PA_ALT_LOC_X   = 8'h1A;
    localparam logic [7:0] PA_ALT_LOC_Y   = 8'h1B;
    localparam logic [7:0] PA_ALT_BOTINFO = 8'h1C;
    localparam logic [7:0] PA_ALT_SENSORS = 8'h1D;
    localparam logic [7:0] PA_ALT_LMDIST  = 8'h1E;
    localparam logic [7:0] PA_ALT_RMDIST  = 8'h1F;
    localparam logic [7:0] PA_INTDONE     = 8'h20;
    localparam logic [7:0] PA_STATUS      = 8'h21;
    localparam logic [7:0] PA_OVRCNT      = 8'h22;

    function automatic logic is_snap_port(input logic [7:0] addr);
        return (addr[7:5] == 3'b000) && (addr[3:0] >= 4'hA);
    endfunction

endpackage

// File: rtl/svc_timer.sv
// Service-phase watchdog: counts cycles spent in SERVICE and flags the last
// permitted cycle so the FSM can leave on the following edge.
module svc_timer #(
    parameter int TMO_W       = 16,
    parameter int SVC_TIMEOUT = 50000
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = (count_q == TMO_W'(SVC_TIMEOUT - 1));

endmodule

// File: rtl/bot_snapshot_intc.sv
// Captures the Rojobot status registers on each update, freezes them while the
// PicoBlaze ISR runs, and handles the request/ack/done interrupt handshake.
module bot_snapshot_intc
    import bot_if_pkg::*;
#(
    parameter int OVR_W       = 8,
    parameter int TMO_W       = 16,
    parameter int SVC_TIMEOUT = 50000
) (
    input  logic             sysclk,
    input  logic             sysreset,
    input  logic             upd_sysregs,
    input  logic [7:0]       loc_x_in,
    input  logic [7:0]       loc_y_in,
    input  logic [7:0]       botinfo_in,
    input  logic [7:0]       sensors_in,
    input  logic [7:0]       lmdist_in,
    input  logic [7:0]       rmdist_in,
    input  logic             interrupt_ack,
    input  logic             isr_done,
    input  logic             clr_status,
    output logic [7:0]       loc_x,
    output logic [7:0]       loc_y,
    output logic [7:0]       botinfo,
    output logic [7:0]       sensors,
    output logic [7:0]       lmdist,
    output logic [7:0]       rmdist,
    output logic             interrupt_request,
    output logic [OVR_W-1:0] ovr_count,
    output logic [7:0]       status
);

    localparam logic [OVR_W-1:0] OVR_MAX = {OVR_W{1'b1}};

    intc_state_t      state_q, state_d;
    logic             upd_q;
    logic             upd_edge;
    logic             deferred_q, deferred_d;
    logic             tmo_q, tmo_d;
    logic             irq_q;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic             capture;
    logic             ovr_inc;
    logic             tmo_set;
    logic             tmo_expired;

    logic [7:0] live [SNAP_N];
    logic [7:0] snap_q [SNAP_N];

    assign live[0] = loc_x_in;
    assign live[1] = loc_y_in;
    assign live[2] = botinfo_in;
    assign live[3] = sensors_in;
    assign live[4] = lmdist_in;
    assign live[5] = rmdist_in;

    assign upd_edge = upd_sysregs & ~upd_q;

    svc_timer #(
        .TMO_W       (TMO_W),
        .SVC_TIMEOUT (SVC_TIMEOUT)
    ) u_svc_timer (
        .clk     (sysclk),
        .srst    (sysreset),
        .clr     (state_q != ST_SERVICE),
        .en      (state_q == ST_SERVICE),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        deferred_d = deferred_q;
        capture    = 1'b0;
        ovr_inc    = 1'b0;
        tmo_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (upd_edge) begin
                    capture = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // Nothing has been read yet, so a newer update simply replaces it.
                if (upd_edge) begin
                    capture = 1'b1;
                    ovr_inc = 1'b1;
                end
                if (interrupt_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (upd_edge) begin
                    if (deferred_q) begin
                        ovr_inc = 1'b1;
                    end else begin
                        deferred_d = 1'b1;
                    end
                end
                if (isr_done || tmo_expired) begin
                    tmo_set = tmo_expired;
                    if (deferred_q || upd_edge) begin
                        capture    = 1'b1;
                        deferred_d = 1'b0;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ovr_d = ovr_q;
        if (clr_status) begin
            ovr_d = ovr_inc ? OVR_W'(1) : '0;
        end else if (ovr_inc && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + 1'b1;
        end
        tmo_d = tmo_set | (tmo_q & ~clr_status);
    end

    always_ff @(posedge sysclk) begin
        if (sysreset) begin
            state_q    <= ST_IDLE;
            upd_q      <= 1'b0;
            deferred_q <= 1'b0;
            tmo_q      <= 1'b0;
            irq_q      <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            upd_q      <= upd_sysregs;
            deferred_q <= deferred_d;
            tmo_q      <= tmo_d;
            irq_q      <= (state_d == ST_REQ);
            ovr_q      <= ovr_d;
        end
    end

    for (genvar gi = 0; gi < SNAP_N; gi++) begin : g_snap
        always_ff @(posedge sysclk) begin
            if (sysreset) begin
                snap_q[gi] <= '0;
            end else if (capture) begin
                snap_q[gi] <= live[gi];
            end
        end
    end

    assign loc_x             = snap_q[0];
    assign loc_y             = snap_q[1];
    assign botinfo           = snap_q[2];
    assign sensors           = snap_q[3];
    assign lmdist            = snap_q[4];
    assign rmdist            = snap_q[5];
    assign interrupt_request = irq_q;
    assign ovr_count         = ovr_q;

    always_comb begin
        status                              = '0;
        status[STS_TMO_BIT]                 = tmo_q;
        status[STS_DEF_BIT]                 = deferred_q;
        status[STS_STATE_HI:STS_STATE_LO]   = state_q;
    end

endmodule

// File: tb/tb_bot_snapshot_intc.sv
// Bench for bot_snapshot_intc: two instances (8-bit and 2-bit overrun counter)
// share stimulus and are compared every cycle against a behavioural model.
module tb_bot_snapshot_intc;

    localparam int T = 10;

    logic       sysclk = 1'b0;
    logic       sysreset = 1'b1;
    logic       upd = 1'b0;
    logic [7:0] lx = '0, ly = '0, bi = '0, se = '0, lm = '0, rm = '0;
    logic       ack = 1'b0, done = 1'b0, clr = 1'b0;

    logic [7:0] a_loc_x, a_loc_y, a_botinfo, a_sensors, a_lmdist, a_rmdist, a_status, a_ovr;
    logic       a_irq;
    logic [7:0] b_loc_x, b_loc_y, b_botinfo, b_sensors, b_lmdist, b_rmdist, b_status;
    logic [1:0] b_ovr;
    logic       b_irq;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    always #5 sysclk = ~sysclk;

    bot_snapshot_intc #(.OVR_W(8), .TMO_W(16), .SVC_TIMEOUT(T)) u_dut_a (
        .sysclk(sysclk), .sysreset(sysreset), .upd_sysregs(upd),
        .loc_x_in(lx), .loc_y_in(ly), .botinfo_in(bi), .sensors_in(se),
        .lmdist_in(lm), .rmdist_in(rm),
        .interrupt_ack(ack), .isr_done(done), .clr_status(clr),
        .loc_x(a_loc_x), .loc_y(a_loc_y), .botinfo(a_botinfo), .sensors(a_sensors),
        .lmdist(a_lmdist), .rmdist(a_rmdist),
        .interrupt_request(a_irq), .ovr_count(a_ovr), .status(a_status)
    );

    bot_snapshot_intc #(.OVR_W(2), .TMO_W(16), .SVC_TIMEOUT(T)) u_dut_b (
        .sysclk(sysclk), .sysreset(sysreset), .upd_sysregs(upd),
        .loc_x_in(lx), .loc_y_in(ly), .botinfo_in(bi), .sensors_in(se),
        .lmdist_in(lm), .rmdist_in(rm),
        .interrupt_ack(ack), .isr_done(done), .clr_status(clr),
        .loc_x(b_loc_x), .loc_y(b_loc_y), .botinfo(b_botinfo), .sensors(b_sensors),
        .lmdist(b_lmdist), .rmdist(b_rmdist),
        .interrupt_request(b_irq), .ovr_count(b_ovr), .status(b_status)
    );

    // Behavioural model: 0 = idle, 1 = waiting for ack, 2 = ISR running.
    int         m_state = 0;
    logic [7:0] m_snap [6];
    bit         m_def = 0, m_tmo = 0, m_upd_prev = 0;
    int         m_ovr_a = 0, m_ovr_b = 0;
    int         m_svc_cycles = 0;

    initial for (int i = 0; i < 6; i++) m_snap[i] = '0;

    always @(posedge sysclk) begin
        bit e, lost, cap, tmo_hit, nd;
        int ns;
        e = upd && !m_upd_prev;
        if (sysreset) begin
            m_state = 0; m_def = 0; m_tmo = 0; m_upd_prev = 0;
            m_ovr_a = 0; m_ovr_b = 0; m_svc_cycles = 0;
            for (int i = 0; i < 6; i++) m_snap[i] = '0;
        end else begin
            m_upd_prev = upd;
            lost = 0; cap = 0; tmo_hit = 0; ns = m_state; nd = m_def;
            if (m_state == 0) begin
                if (e) begin cap = 1; ns = 1; end
            end else if (m_state == 1) begin
                if (e) begin cap = 1; lost = 1; end
                if (ack) begin ns = 2; m_svc_cycles = 0; end
            end else begin
                m_svc_cycles++;
                tmo_hit = (m_svc_cycles == T);
                if (e) begin
                    if (m_def) lost = 1; else nd = 1;
                end
                if (done || tmo_hit) begin
                    if (m_def || e) begin cap = 1; nd = 0; ns = 1; end
                    else ns = 0;
                end
            end
            if (clr) begin
                m_ovr_a = lost ? 1 : 0;
                m_ovr_b = lost ? 1 : 0;
            end else if (lost) begin
                m_ovr_a = (m_ovr_a + 1 > 255) ? 255 : m_ovr_a + 1;
                m_ovr_b = (m_ovr_b + 1 > 3) ? 3 : m_ovr_b + 1;
            end
            m_tmo = tmo_hit || (m_tmo && !clr);
            if (cap) begin
                m_snap[0] = lx; m_snap[1] = ly; m_snap[2] = bi;
                m_snap[3] = se; m_snap[4] = lm; m_snap[5] = rm;
            end
            m_state = ns;
            m_def = nd;
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge sysclk) begin
        int st;
        if (chk_en) begin
            st = (int'(m_tmo) << 7) | (int'(m_def) << 6) | m_state;
            cmp("a_loc_x", a_loc_x, m_snap[0]);   cmp("b_loc_x", b_loc_x, m_snap[0]);
            cmp("a_loc_y", a_loc_y, m_snap[1]);   cmp("b_loc_y", b_loc_y, m_snap[1]);
            cmp("a_botinfo", a_botinfo, m_snap[2]); cmp("b_botinfo", b_botinfo, m_snap[2]);
            cmp("a_sensors", a_sensors, m_snap[3]); cmp("b_sensors", b_sensors, m_snap[3]);
            cmp("a_lmdist", a_lmdist, m_snap[4]); cmp("b_lmdist", b_lmdist, m_snap[4]);
            cmp("a_rmdist", a_rmdist, m_snap[5]); cmp("b_rmdist", b_rmdist, m_snap[5]);
            cmp("a_irq", a_irq, m_state == 1);    cmp("b_irq", b_irq, m_state == 1);
            cmp("a_status", a_status, st);        cmp("b_status", b_status, st);
            cmp("a_ovr", a_ovr, m_ovr_a);         cmp("b_ovr", b_ovr, m_ovr_b);
        end
    end

    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic upd_pulse();
        upd = 1'b1; step(); upd = 1'b0; step();
    endtask

    initial begin
        step(); step();
        chk_en = 1;
        cmp("rst_irq", a_irq, 0);
        cmp("rst_status", a_status, 0);
        cmp("rst_ovr", a_ovr, 0);
        cmp("rst_loc_x", a_loc_x, 0);
        sysreset = 1'b0; step();

        lx = 8'h12; se = 8'h05; upd = 1'b1; step();
        cmp("cap_loc_x", a_loc_x, 8'h12);
        cmp("cap_sensors", a_sensors, 8'h05);
        cmp("cap_irq", a_irq, 1);
        cmp("cap_state", a_status[1:0], 1);

        upd = 1'b0; ack = 1'b1; step(); ack = 1'b0;
        cmp("ack_irq", a_irq, 0);
        cmp("ack_state", a_status[1:0], 2);
        lx = 8'h34; upd = 1'b1; step(); upd = 1'b0;
        cmp("frz_loc_x", a_loc_x, 8'h12);
        cmp("def_set", a_status[6], 1);
        step();
        done = 1'b1; step(); done = 1'b0;
        cmp("rereq_loc_x", a_loc_x, 8'h34);
        cmp("rereq_irq", a_irq, 1);
        cmp("rereq_def", a_status[6], 0);

        ack = 1'b1; step(); ack = 1'b0;
        repeat (3) upd_pulse();
        done = 1'b1; step(); done = 1'b0;
        repeat (2) upd_pulse();
        cmp("ovr_four", a_ovr, 4);
        cmp("ovr_sat_b", b_ovr, 3);
        cmp("ovr_state", a_status[1:0], 1);
        clr = 1'b1; step(); clr = 1'b0;
        cmp("ovr_clr_a", a_ovr, 0);
        cmp("ovr_clr_b", b_ovr, 0);

        ack = 1'b1; step(); ack = 1'b0;
        repeat (T - 1) step();
        cmp("tmo_pre_state", a_status[1:0], 2);
        step();
        cmp("tmo_state", a_status[1:0], 0);
        cmp("tmo_sticky", a_status[7], 1);
        cmp("tmo_irq", a_irq, 0);
        clr = 1'b1; step(); clr = 1'b0;
        cmp("tmo_clr", a_status[7], 0);

        repeat (7) upd_pulse();
        cmp("sat6_a", a_ovr, 6);
        cmp("sat6_b", b_ovr, 3);

        ack = 1'b1; step(); ack = 1'b0;
        upd = 1'b1; step(); upd = 1'b0;
        cmp("pre_rst_def", a_status[6], 1);
        sysreset = 1'b1; step(); sysreset = 1'b0;
        cmp("mid_rst_loc_x", a_loc_x, 0);
        cmp("mid_rst_irq", a_irq, 0);
        cmp("mid_rst_ovr", a_ovr, 0);
        cmp("mid_rst_status", a_status, 0);
        lx = 8'h56; upd = 1'b1; step(); upd = 1'b0;
        cmp("post_rst_loc_x", a_loc_x, 8'h56);
        cmp("post_rst_irq", a_irq, 1);

        for (int n = 0; n < 4000; n++) begin
            sysreset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) upd = ~upd;
            ack  = ($urandom_range(0, 3) == 0);
            done = ($urandom_range(0, 9) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            lx = 8'($urandom); ly = 8'($urandom); bi = 8'($urandom);
            se = 8'($urandom); lm = 8'($urandom); rm = 8'($urandom);
            step();
        end

        sysreset = 1'b0; upd = 1'b0; ack = 1'b0; done = 1'b0; clr = 1'b0;
        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
